// File: rtl/y86_pkg.sv
// y86_pkg: shared constants and types for the handshaked y86 sequencer.
//   - opcode and mod-field constants for the supported instruction subset
//   - state_t: sequencer FSM states
//   - kind_t:  decoded instruction class
//   - decode_kind / instr_len: decode helpers shared by the datapath and FSM
package y86_pkg;

    localparam logic [7:0] OP_MOV_ST = 8'h89;
    localparam logic [7:0] OP_LD     = 8'h8B;
    localparam logic [7:0] OP_ADD    = 8'h01;
    localparam logic [7:0] OP_SUB    = 8'h29;
    localparam logic [7:0] OP_JNZ    = 8'h75;
    localparam logic [7:0] OP_HLT    = 8'hF4;

    localparam logic [1:0] MOD_REG   = 2'd3;
    localparam logic [1:0] MOD_DISP8 = 2'd1;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        K_MOV     = 3'd0,
        K_STORE   = 3'd1,
        K_LOAD    = 3'd2,
        K_ADD     = 3'd3,
        K_SUB     = 3'd4,
        K_JNZ     = 3'd5,
        K_HALT    = 3'd6,
        K_ILLEGAL = 3'd7
    } kind_t;

    // Classify an opcode/mod pair; anything not listed is illegal.
    function automatic kind_t decode_kind(input logic [7:0] op, input logic [1:0] md);
        kind_t k;
        case (op)
            OP_MOV_ST: begin
                if (md == MOD_REG) begin
                    k = K_MOV;
                end else if (md == MOD_DISP8) begin
                    k = K_STORE;
                end else begin
                    k = K_ILLEGAL;
                end
            end
            OP_LD:   k = (md == MOD_DISP8) ? K_LOAD : K_ILLEGAL;
            OP_ADD:  k = K_ADD;
            OP_SUB:  k = K_SUB;
            OP_JNZ:  k = K_JNZ;
            OP_HLT:  k = K_HALT;
            default: k = K_ILLEGAL;
        endcase
        return k;
    endfunction

    // Instruction length in bytes.
    function automatic logic [1:0] instr_len(input kind_t k);
        logic [1:0] len;
        case (k)
            K_LOAD, K_STORE:      len = 2'd3;
            K_MOV, K_ADD,
            K_SUB, K_JNZ:         len = 2'd2;
            default:              len = 2'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// y86_regfile: 8 x DATA_W register file.
//   clk, rst           : clock, synchronous active-high reset (clears all entries)
//   ra, rb             : asynchronous read addresses
//   rdata_a, rdata_b   : asynchronous read data
//   we, wa, wd         : synchronous write port
module y86_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        ra,
    input  logic [2:0]        rb,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [2:0]        wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs_r [0:7];

    // Register storage: reset clears, otherwise single write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we) begin
            regs_r[wa] <= wd;
        end
    end

    assign rdata_a = regs_r[ra];
    assign rdata_b = regs_r[rb];

endmodule

// File: rtl/y86_seq_hs.sv
// y86_seq_hs: multi-cycle y86 subset sequencer on a ready-handshaked bus.
//   clk, rst        : clock, synchronous active-high reset
//   bus_addr        : IP in FETCH, effective address in MEM, else 0
//   bus_rdata       : read data (instruction bytes little-endian in [31:0])
//   bus_wdata       : store data
//   bus_re, bus_we  : read / write request, held until bus_ready
//   bus_ready       : completes the current request in the same cycle
//   halted          : core sits in HALT
//   illegal         : sticky, HALT entered on an undecodable opcode
//   current_opcode  : IR[7:0]
// Optional build macro Y86_PERF_CNT_EN adds saturating counters:
//   perf_retired    : completed instructions (halt included)
//   perf_wait       : cycles with a request pending and bus_ready low
module y86_seq_hs
    import y86_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_IP = {ADDR_W{1'b0}},
    parameter int                BASE_REG = 6
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_re,
    output logic              bus_we,
    input  logic              bus_ready,
    output logic              halted,
    output logic              illegal,
    output logic [7:0]        current_opcode
`ifdef Y86_PERF_CNT_EN
    ,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_wait
`endif
);

    localparam logic [2:0] BASE_IDX = BASE_REG[2:0];

    state_t            state_r;
    state_t            state_nx_s;
    logic [ADDR_W-1:0] ip_r;
    logic [23:0]       ir_r;      // byte 3 of the fetch word is never decoded
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] res_r;
    logic [ADDR_W-1:0] addr_r;
    logic              zf_r;
    logic              illegal_r;

    kind_t             kind_s;
    logic              is_mem_s;
    logic [2:0]        rd_s;
    logic [2:0]        rs_s;
    logic [DATA_W-1:0] disp_s;
    logic [ADDR_W-1:0] dist_s;
    logic [ADDR_W-1:0] len_s;
    logic [ADDR_W-1:0] next_ip_s;
    logic [DATA_W-1:0] alu_s;
    logic [DATA_W-1:0] rdata_a_s;
    logic [DATA_W-1:0] rdata_b_s;
    logic              rf_we_s;
    logic [2:0]        rf_wa_s;

    // IR is stable from DECODE through WB, so decode is recomputed each cycle.
    assign kind_s    = decode_kind(ir_r[7:0], ir_r[15:14]);
    assign is_mem_s  = (kind_s == K_LOAD) || (kind_s == K_STORE);
    assign rd_s      = ir_r[10:8];
    assign rs_s      = ir_r[13:11];
    assign disp_s    = {{(DATA_W-8){ir_r[23]}}, ir_r[23:16]};
    assign dist_s    = {{(ADDR_W-8){ir_r[15]}}, ir_r[15:8]};
    assign len_s     = {{(ADDR_W-2){1'b0}}, instr_len(kind_s)};
    // jnz offset is relative to the following instruction.
    assign next_ip_s = ip_r + len_s +
                       (((kind_s == K_JNZ) && !zf_r) ? dist_s : {ADDR_W{1'b0}});

    // ALU; sub is two's-complement add of the inverted operand.
    always_comb begin
        alu_s = b_r;
        case (kind_s)
            K_ADD:   alu_s = a_r + b_r;
            K_SUB:   alu_s = a_r + ~b_r + {{(DATA_W-1){1'b0}}, 1'b1};
            K_MOV:   alu_s = b_r;
            default: alu_s = b_r;
        endcase
    end

    assign rf_we_s = (state_r == ST_WB) && !rst;
    assign rf_wa_s = (kind_s == K_LOAD) ? rs_s : rd_s;

    y86_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra      (is_mem_s ? BASE_IDX : rd_s),
        .rb      (rs_s),
        .rdata_a (rdata_a_s),
        .rdata_b (rdata_b_s),
        .we      (rf_we_s),
        .wa      (rf_wa_s),
        .wd      (res_r)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (bus_ready) begin
                    state_nx_s = ST_DECODE;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if ((kind_s == K_HALT) || (kind_s == K_ILLEGAL)) begin
                    state_nx_s = ST_HALT;
                end else begin
                    state_nx_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_mem_s) begin
                    state_nx_s = ST_MEM;
                end else if (kind_s == K_JNZ) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (!bus_ready) begin
                    state_nx_s = ST_MEM;
                end else if (kind_s == K_LOAD) begin
                    state_nx_s = ST_WB;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_WB:   state_nx_s = ST_FETCH;
            ST_HALT: state_nx_s = ST_HALT;
            default: state_nx_s = ST_FETCH;
        endcase
    end

    // Bus request decode; reset suppresses any request immediately.
    always_comb begin
        bus_re    = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = {ADDR_W{1'b0}};
        bus_wdata = {DATA_W{1'b0}};
        if (!rst) begin
            case (state_r)
                ST_FETCH: begin
                    bus_re   = 1'b1;
                    bus_addr = ip_r;
                end
                ST_MEM: begin
                    bus_addr = addr_r;
                    if (kind_s == K_STORE) begin
                        bus_we    = 1'b1;
                        bus_wdata = b_r;
                    end else begin
                        bus_re = 1'b1;
                    end
                end
                default: begin
                    bus_re = 1'b0;
                end
            endcase
        end else begin
            bus_re = 1'b0;
        end
    end

    // Datapath registers: IR, IP, operand latches, ZF and the illegal flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ip_r      <= RESET_IP;
            ir_r      <= 24'h000000;
            a_r       <= {DATA_W{1'b0}};
            b_r       <= {DATA_W{1'b0}};
            res_r     <= {DATA_W{1'b0}};
            addr_r    <= {ADDR_W{1'b0}};
            zf_r      <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (bus_ready) begin
                        ir_r <= bus_rdata[23:0];
                    end
                end
                ST_DECODE: begin
                    a_r <= rdata_a_s;
                    b_r <= rdata_b_s;
                    if (kind_s == K_ILLEGAL) begin
                        illegal_r <= 1'b1;
                    end else if (kind_s != K_HALT) begin
                        ip_r <= next_ip_s;
                    end
                end
                ST_EXEC: begin
                    res_r  <= alu_s;
                    addr_r <= ADDR_W'(a_r + disp_s);
                    if ((kind_s == K_ADD) || (kind_s == K_SUB)) begin
                        zf_r <= (alu_s == {DATA_W{1'b0}});
                    end
                end
                ST_MEM: begin
                    if (bus_ready && (kind_s == K_LOAD)) begin
                        res_r <= bus_rdata;
                    end
                end
                default: begin
                    res_r <= res_r;
                end
            endcase
        end
    end

    assign halted         = (state_r == ST_HALT) && !rst;
    assign illegal        = illegal_r;
    assign current_opcode = ir_r[7:0];

`ifdef Y86_PERF_CNT_EN
    logic retire_s;
    logic wait_s;

    assign retire_s = (state_r == ST_WB) ||
                      ((state_r == ST_EXEC) && (kind_s == K_JNZ)) ||
                      ((state_r == ST_MEM) && bus_ready && (kind_s == K_STORE)) ||
                      ((state_r == ST_DECODE) && (kind_s == K_HALT));
    assign wait_s   = (bus_re || bus_we) && !bus_ready;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_retired <= 32'h00000000;
            perf_wait    <= 32'h00000000;
        end else begin
            if (retire_s && (perf_retired != 32'hFFFFFFFF)) begin
                perf_retired <= perf_retired + 32'd1;
            end
            if (wait_s && (perf_wait != 32'hFFFFFFFF)) begin
                perf_wait <= perf_wait + 32'd1;
            end
        end
    end
`endif

endmodule
